// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to
// instruction memory and fills the IF/ID register through a one-entry hold buffer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_offset,
    input  logic        jump,
    input  logic [31:0] j_addr_extend,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        flush_id,
    output logic        misalign
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_DROP
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        req_reg, req_next;
    logic        hold_valid_reg, hold_valid_next;
    logic [31:0] hold_instr_reg, hold_instr_next;
    logic [31:0] hold_pc_reg, hold_pc_next;
    logic        ifid_valid_reg, ifid_valid_next;
    logic [31:0] ifid_instr_reg, ifid_instr_next;
    logic [31:0] ifid_pc_reg, ifid_pc_next;
    logic [31:0] ifid_pc4_reg, ifid_pc4_next;
    logic        flush_reg, flush_next;
    logic        misalign_reg, misalign_next;

    logic        redirect;
    logic        accept;
    logic        outstanding;
    logic        loaded;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] raw_target;

    always_comb begin
        redirect      = br_taken | jump;
        accept        = req_reg & imem_ready;
        branch_target = br_pc + 32'd4 + (br_offset << 2);
        jump_target   = j_addr_extend << 2;
        raw_target    = jump ? jump_target : branch_target;

        state_next      = state_reg;
        pc_next         = pc_reg;
        hold_valid_next = hold_valid_reg;
        hold_instr_next = hold_instr_reg;
        hold_pc_next    = hold_pc_reg;
        ifid_valid_next = ifid_valid_reg;
        ifid_instr_next = ifid_instr_reg;
        ifid_pc_next    = ifid_pc_reg;
        ifid_pc4_next   = ifid_pc4_reg;
        flush_next      = 1'b0;
        misalign_next   = 1'b0;
        outstanding     = 1'b0;
        loaded          = 1'b0;

        if (redirect) begin
            // Redirect beats stall; a response arriving this very cycle is wrong-path.
            pc_next         = {raw_target[31:2], 2'b00};
            ifid_valid_next = 1'b0;
            hold_valid_next = 1'b0;
            flush_next      = 1'b1;
            misalign_next   = |raw_target[1:0];
            outstanding     = ((state_reg == ST_REQ) && accept) ||
                              ((state_reg != ST_REQ) && !imem_rvalid);
            state_next      = outstanding ? ST_DROP : ST_REQ;
        end else begin
            case (state_reg)
                ST_REQ: begin
                    if (accept) state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state_next = ST_REQ;
                        pc_next    = pc_reg + 32'd4;
                        if (stall) begin
                            hold_valid_next = 1'b1;
                            hold_instr_next = imem_rdata;
                            hold_pc_next    = pc_reg;
                        end else begin
                            ifid_valid_next = 1'b1;
                            ifid_instr_next = imem_rdata;
                            ifid_pc_next    = pc_reg;
                            ifid_pc4_next   = pc_reg + 32'd4;
                            loaded          = 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid) state_next = ST_REQ;
                end
                default: state_next = ST_REQ;
            endcase

            if (!stall && !loaded) begin
                if (hold_valid_reg) begin
                    ifid_valid_next = 1'b1;
                    ifid_instr_next = hold_instr_reg;
                    ifid_pc_next    = hold_pc_reg;
                    ifid_pc4_next   = hold_pc_reg + 32'd4;
                    hold_valid_next = 1'b0;
                end else begin
                    ifid_valid_next = 1'b0;
                end
            end
        end

        // Request line is a registered decode; a full hold buffer keeps it low.
        req_next = (state_next == ST_REQ) && !hold_valid_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_REQ;
            pc_reg         <= RESET_PC;
            req_reg        <= 1'b0;
            hold_valid_reg <= 1'b0;
            hold_instr_reg <= 32'd0;
            hold_pc_reg    <= 32'd0;
            ifid_valid_reg <= 1'b0;
            ifid_instr_reg <= 32'd0;
            ifid_pc_reg    <= 32'd0;
            ifid_pc4_reg   <= 32'd0;
            flush_reg      <= 1'b0;
            misalign_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            req_reg        <= req_next;
            hold_valid_reg <= hold_valid_next;
            hold_instr_reg <= hold_instr_next;
            hold_pc_reg    <= hold_pc_next;
            ifid_valid_reg <= ifid_valid_next;
            ifid_instr_reg <= ifid_instr_next;
            ifid_pc_reg    <= ifid_pc_next;
            ifid_pc4_reg   <= ifid_pc4_next;
            flush_reg      <= flush_next;
            misalign_reg   <= misalign_next;
        end
    end

    assign imem_req   = req_reg;
    assign imem_addr  = pc_reg;
    assign ifid_valid = ifid_valid_reg;
    assign ifid_instr = ifid_instr_reg;
    assign ifid_pc    = ifid_pc_reg;
    assign ifid_pc4   = ifid_pc4_reg;
    assign flush_id   = flush_reg;
    assign misalign   = misalign_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, br_taken, jump, imem_ready, imem_rvalid;
    logic [31:0] br_pc, br_offset, j_addr_extend, imem_rdata;
    logic        imem_req, ifid_valid, flush_id, misalign;
    logic [31:0] imem_addr, ifid_instr, ifid_pc, ifid_pc4;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .br_taken(br_taken), .br_pc(br_pc), .br_offset(br_offset),
        .jump(jump), .j_addr_extend(j_addr_extend),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .ifid_pc4(ifid_pc4), .flush_id(flush_id), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // memory: at most one response in flight
    logic        mem_pend;
    logic [31:0] mem_addr;
    int          mem_due;
    int          lat;
    logic        stale_data;

    // reference model: fetch pointer, in-flight request, pending words, IF/ID view
    logic [31:0] m_pc;
    logic        m_busy, m_discard, m_req;
    logic [63:0] m_hold[$];
    logic        m_iv;
    logic [31:0] m_ii, m_ip;
    logic        m_flush, m_mis;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2000_0001;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_busy = 1'b0; m_discard = 1'b0; m_req = 1'b0;
        m_hold.delete();
        m_iv = 1'b0; m_ii = 32'h0; m_ip = 32'h0;
        m_flush = 1'b0; m_mis = 1'b0;
        mem_pend = 1'b0;
    endtask

    task automatic set_ctl(input logic s, input logic b, input logic j,
                           input logic [31:0] bpc, input logic [31:0] boff,
                           input logic [31:0] jx);
        stall = s; br_taken = b; jump = j;
        br_pc = bpc; br_offset = boff; j_addr_extend = jx;
    endtask

    task automatic model_step();
        logic [31:0] raw;
        logic        accept, loaded;
        accept = m_req && imem_ready;
        loaded = 1'b0;
        if (br_taken || jump) begin
            raw     = jump ? (j_addr_extend * 32'd4) : (br_pc + 32'd4 + br_offset * 32'd4);
            m_pc    = raw & 32'hFFFF_FFFC;
            m_iv    = 1'b0;
            m_hold.delete();
            m_flush = 1'b1;
            m_mis   = (raw[1:0] != 2'b00);
            if (accept) begin
                m_busy = 1'b1; m_discard = 1'b1;
            end else if (m_busy && !imem_rvalid) begin
                m_discard = 1'b1;
            end else begin
                m_busy = 1'b0; m_discard = 1'b0;
            end
        end else begin
            m_flush = 1'b0;
            m_mis   = 1'b0;
            if (m_busy && imem_rvalid) begin
                m_busy = 1'b0;
                if (!m_discard) begin
                    if (stall) begin
                        m_hold.push_back({imem_rdata, m_pc});
                    end else begin
                        m_iv = 1'b1; m_ii = imem_rdata; m_ip = m_pc; loaded = 1'b1;
                        $display("ifid load pc=%h instr=%h (cycle %0d)", m_ip, m_ii, cyc);
                    end
                    m_pc = m_pc + 32'd4;
                end
                m_discard = 1'b0;
            end else if (accept) begin
                m_busy = 1'b1; m_discard = 1'b0;
            end
            if (!stall && !loaded) begin
                if (m_hold.size() > 0) begin
                    {m_ii, m_ip} = m_hold.pop_front();
                    m_iv = 1'b1;
                    $display("ifid drain pc=%h instr=%h (cycle %0d)", m_ip, m_ii, cyc);
                end else begin
                    m_iv = 1'b0;
                end
            end
        end
        m_req = !m_busy && (m_hold.size() == 0);
    endtask

    task automatic check_outputs();
        chk("imem_req", 32'(imem_req), 32'(m_req));
        if (m_req) chk("imem_addr", imem_addr, m_pc);
        chk("ifid_valid", 32'(ifid_valid), 32'(m_iv));
        if (m_iv) begin
            chk("ifid_instr", ifid_instr, m_ii);
            chk("ifid_pc", ifid_pc, m_ip);
            chk("ifid_pc4", ifid_pc4, m_ip + 32'd4);
        end
        chk("flush_id", 32'(flush_id), 32'(m_flush));
        chk("misalign", 32'(misalign), 32'(m_mis));
    endtask

    // One clock cycle: compare, drive memory side, advance model, wait for next negedge.
    task automatic tick();
        logic        acc;
        logic [31:0] acc_addr;
        check_outputs();
        imem_rvalid = mem_pend && (cyc == mem_due);
        imem_rdata  = imem_rvalid ? (stale_data ? 32'hDEAD_BEEF : mem_word(mem_addr)) : $urandom();
        acc      = m_req && imem_ready;
        acc_addr = m_pc;
        if (imem_rvalid) mem_pend = 1'b0;
        model_step();
        if (acc) begin
            mem_pend = 1'b1; mem_addr = acc_addr; mem_due = cyc + lat;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'h0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_valid"}, 32'(ifid_valid), 32'h0);
        chk({tag, "_instr"}, ifid_instr, 32'h0);
        chk({tag, "_pc"}, ifid_pc, 32'h0);
        chk({tag, "_pc4"}, ifid_pc4, 32'h0);
        chk({tag, "_flush"}, 32'(flush_id), 32'h0);
        chk({tag, "_mis"}, 32'(misalign), 32'h0);
    endtask

    task automatic do_reset_mid();
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        model_reset();
        imem_rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          n;
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        lat = 1; stale_data = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("rst_init");
        rst_n = 1'b1;

        // first fetch after reset
        imem_ready = 1'b1;
        tick();
        chk("t1_req", 32'(imem_req), 32'h1);
        chk("t1_addr", imem_addr, 32'h0);
        tick();
        tick();
        chk("t1_valid", 32'(ifid_valid), 32'h1);
        chk("t1_instr", ifid_instr, 32'h2000_0001);
        chk("t1_pc", ifid_pc, 32'h0);
        chk("t1_pc4", ifid_pc4, 32'h4);
        chk("t1_next", imem_addr, 32'h4);

        // taken branch with negative offset
        imem_ready = 1'b0;
        set_ctl(1'b0, 1'b1, 1'b0, 32'h100, 32'hFFFF_FFFC, 32'h0);
        tick();
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("t2_flush", 32'(flush_id), 32'h1);
        chk("t2_valid", 32'(ifid_valid), 32'h0);
        chk("t2_addr", imem_addr, 32'hF4);
        tick();
        chk("t2_pulse", 32'(flush_id), 32'h0);

        // jump beats a simultaneous (misaligned) branch
        set_ctl(1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 32'h40);
        tick();
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("t3_addr", imem_addr, 32'h100);
        chk("t3_mis", 32'(misalign), 32'h0);

        // misaligned branch target
        set_ctl(1'b0, 1'b1, 1'b0, 32'h202, 32'h1, 32'h0);
        tick();
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("mis_addr", imem_addr, 32'h208);
        chk("mis_pulse", 32'(misalign), 32'h1);
        tick();
        chk("mis_clear", 32'(misalign), 32'h0);

        // back-to-back redirects: last one wins
        set_ctl(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 32'h0);
        tick();
        chk("b2b_addr1", imem_addr, 32'h404);
        set_ctl(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h30);
        tick();
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("b2b_flush2", 32'(flush_id), 32'h1);
        chk("b2b_addr2", imem_addr, 32'hC0);

        // redirect in WAIT, stale response two cycles later
        imem_ready = 1'b1; lat = 3;
        tick();
        imem_ready = 1'b0;
        set_ctl(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h80);
        tick();
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("t4_flush", 32'(flush_id), 32'h1);
        chk("t4_req_drop", 32'(imem_req), 32'h0);
        stale_data = 1'b1;
        tick();
        tick();
        stale_data = 1'b0;
        chk("t4_req", 32'(imem_req), 32'h1);
        chk("t4_addr", imem_addr, 32'h200);
        chk("t4_novalid", 32'(ifid_valid), 32'h0);
        lat = 1; imem_ready = 1'b1;
        n = 0;
        while (!ifid_valid && n < 10) begin
            tick();
            n++;
        end
        chk("t4_valid", 32'(ifid_valid), 32'h1);
        chk("t4_pc", ifid_pc, 32'h200);
        chk("t4_instr", ifid_instr, mem_word(32'h200));

        // stall while a response arrives: word parks in the hold buffer
        tick();
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t5_noreq", 32'(imem_req), 32'h0);
            chk("t5_hold_pc", ifid_pc, 32'h200);
        end
        stall = 1'b0;
        tick();
        chk("t5_valid", 32'(ifid_valid), 32'h1);
        chk("t5_pc", ifid_pc, 32'h204);
        chk("t5_instr", ifid_instr, mem_word(32'h204));
        chk("t5_next", imem_addr, 32'h208);

        // reset asserted while waiting for a response
        lat = 3;
        tick();
        do_reset_mid();
        tick();
        chk("t6_req", 32'(imem_req), 32'h1);
        chk("t6_addr", imem_addr, 32'h0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                do_reset_mid();
            end
            imem_ready = ($urandom_range(0, 9) < 6);
            lat        = $urandom_range(1, 3);
            stall      = ($urandom_range(0, 3) == 0);
            n          = $urandom_range(0, 99);
            br_taken   = (n < 5);
            jump       = (n >= 3 && n < 7);
            r          = $urandom();
            br_pc      = (n % 4 == 0) ? r : (r & 32'hFFFF_FFFC);
            r          = $urandom();
            br_offset  = {{16{r[15]}}, r[15:0]};
            r          = $urandom();
            j_addr_extend = {{6{r[25]}}, r[25:0]};
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage pipeline. Owns the program counter and issues one-at-a-time requests to instruction memory. Fills the IF/ID pipeline register. Redirects the PC on a taken branch or jump reported from EX by the branch-control unit, squashing any wrong-path work. Honours hazard-unit stalls through a one-entry holding buffer.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit: hold IF/ID contents and PC
- br_taken  in  1  branch-control result, already qualified by EX valid
- br_pc  in  32  PC of the branch/jump instruction in EX
- br_offset  in  32  sign-extended 16-bit branch immediate (word offset)
- jump  in  1  unconditional jump in EX
- j_addr_extend  in  32  sign-extended jump field from branch control (word address)
- imem_req  out  1  request valid
- imem_addr  out  32  word-aligned fetch address
- imem_ready  in  1  memory accepts request when imem_req && imem_ready
- imem_rvalid  in  1  response valid, at least 1 cycle after acceptance
- imem_rdata  in  32  instruction word
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_instr  out  32  instruction
- ifid_pc  out  32  its PC
- ifid_pc4  out  32  its PC + 4
- flush_id  out  1  one-cycle pulse: squash ID stage
- misalign  out  1  one-cycle pulse: redirect target had nonzero bits [1:0]

## Operation
- Targets, 32-bit wrap-around arithmetic: branch = br_pc + 4 + (br_offset << 2); jump = j_addr_extend << 2, truncated to 32 bits.
- Target bits [1:0] are forced to 0. misalign pulses the cycle after the redirect when the raw bits were nonzero.
- Redirect = br_taken | jump. If both are high, the jump target wins. A redirect overrides stall.
- FSM states:
  - REQ: imem_req=1, imem_addr=pc. On accept, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid, deliver the instruction, pc <= pc+4, go to REQ.
  - DROP: an old request is outstanding after a redirect. imem_req=0. Discard the next imem_rvalid, then go to REQ.
- Deliver: if IF/ID is free (not stall), load {instr, pc, pc+4} and set ifid_valid=1. If stall=1, capture into the hold buffer instead, and stay out of REQ until the buffer drains.
- Hold buffer drains into IF/ID on the first cycle stall=0. It has one entry, so the FSM never issues while the buffer is full.
- With stall=1 and no redirect: IF/ID, pc and the hold buffer are held. An outstanding request may still complete into an empty buffer.
- When IF/ID is not loaded and not stalled, ifid_valid=0 (bubble).
- Redirect in any state:
  - pc <= target; IF/ID valid <= 0; hold buffer cleared; flush_id=1 for one cycle.
  - Next state: DROP if a request has been accepted and its response has not yet arrived (including accept in the same cycle), else REQ.
  - An imem_rvalid in the redirect cycle is discarded.
- Reset values: pc=RESET_PC, state=REQ, imem_req=0 during reset, ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pc4=0, flush_id=0, misalign=0, hold buffer empty.
- Reset mid-request: the memory response is not tracked. The first request after reset is to RESET_PC.

## Timing
- imem_req is a registered state decode. It asserts first in the cycle after rst_n deasserts.
- Best-case throughput: one instruction every 2 cycles (accept at N, rvalid at N+1, ifid_valid at N+2, next request at N+2).
- Redirect in cycle R: flush_id high in R+1, imem_addr = target in R+1 if no request is outstanding. The first target instruction reaches IF/ID no earlier than R+3.
- flush_id and misalign are single-cycle pulses. Back-to-back redirects each produce a pulse, and the last one wins the PC.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset release, ready=1, rvalid 1 cycle later, rdata=0x2000_0001 -> first imem_addr=RESET_PC; ifid_valid, ifid_pc=0x0, ifid_pc4=0x4 on cycle 3; next addr=0x4.
- br_taken=1, br_pc=0x100, br_offset=0xFFFF_FFFC -> flush_id pulse, ifid_valid=0, next imem_addr=0xF4.
- jump=1 and br_taken=1 together, j_addr_extend=0x40 -> next imem_addr=0x100 (jump wins), misalign=0.
- Redirect while in WAIT, stale rvalid (rdata=0xDEAD_BEEF) arrives 2 cycles later -> stale word never appears in IF/ID; next request = target; first valid instruction is from the target.
- stall=1 for 4 cycles as a response arrives -> IF/ID unchanged, word held in buffer, no new imem_req; stall drop -> held word loads in the next cycle.
- rst_n low asserted mid-WAIT -> all outputs zero immediately; after release, first request is to RESET_PC.
